// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    // Source selected for the next program counter.
    typedef enum logic [1:0] {
        SEL_HOLD   = 2'b00,
        SEL_SEQ    = 2'b01,
        SEL_BRANCH = 2'b10,
        SEL_JUMP   = 2'b11
    } pc_sel_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Word-granular signed branch immediate turned into a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ID-stage controls, ROM address/data and IF/ID register outputs.
interface fetch_unit_if;

    logic        stall_i;
    logic        branch_taken_i;
    logic [15:0] branch_imm_i;
    logic        jump_i;
    logic [25:0] jump_target_i;
    logic [31:0] rom_data_i;
    logic [31:0] pc_addr_o;
    logic        cs_rom_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_plus4_o;
    logic        ifid_valid_o;
    logic        fetch_fault_o;

    modport master (
        output stall_i, branch_taken_i, branch_imm_i, jump_i, jump_target_i, rom_data_i,
        input  pc_addr_o, cs_rom_o, ifid_instr_o, ifid_pc_plus4_o, ifid_valid_o, fetch_fault_o
    );

    modport slave (
        input  stall_i, branch_taken_i, branch_imm_i, jump_i, jump_target_i, rom_data_i,
        output pc_addr_o, cs_rom_o, ifid_instr_o, ifid_pc_plus4_o, ifid_valid_o, fetch_fault_o
    );

endinterface

// File: rtl/adder_32_bit.sv
// Plain 32-bit modular adder.
module adder_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_unit_ifid_pipe_reg.sv
// IF/ID pipeline register: bubble overrides load, otherwise contents hold.
module ifid_pipe_reg #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        bubble,
    input  logic        load,
    input  logic [31:0] next_instr,
    input  logic [31:0] next_pc_plus4,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= NOP_WORD;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (bubble) begin
            instr    <= NOP_WORD;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (load && !hold) begin
            instr    <= next_instr;
            pc_plus4 <= next_pc_plus4;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch control in front of a combinational instruction ROM.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_DEPTH = 256,
    parameter logic [31:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.slave  bus
);

    localparam logic [31:0] PC_LAST = 32'(ROM_DEPTH - 4);

    state_t      state;
    state_t      state_next;
    pc_sel_t     pc_sel;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        bad;
    logic        cs_rom;
    logic        ifid_hold;
    logic        ifid_bubble;
    logic        ifid_load;
    logic        fault;
    logic        fault_set;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;

    adder_32_bit u_pc_inc (
        .a   (pc),
        .b   (PC_INC),
        .sum (pc_plus4)
    );

    // Branch offset is relative to the pc+4 of the branch sitting in IF/ID.
    adder_32_bit u_branch_add (
        .a   (ifid_pc_plus4),
        .b   (branch_offset(bus.branch_imm_i)),
        .sum (branch_target)
    );

    assign jump_target = {ifid_pc_plus4[31:28], bus.jump_target_i, 2'b00};
    assign bad         = (pc[1:0] != 2'b00) || (pc > PC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = bad ? HALT : RUN;
            HALT:    state_next = HALT;
            default: state_next = HALT;
        endcase
    end

    // Redirect beats stall; branch beats jump.
    always_comb begin
        cs_rom      = 1'b0;
        pc_sel      = SEL_HOLD;
        ifid_hold   = 1'b1;
        ifid_bubble = 1'b0;
        ifid_load   = 1'b0;
        fault_set   = 1'b0;
        unique case (state)
            BOOT: begin
            end
            RUN: begin
                if (bad) begin
                    ifid_hold   = 1'b0;
                    ifid_bubble = 1'b1;
                    fault_set   = 1'b1;
                end else begin
                    cs_rom = 1'b1;
                    if (bus.branch_taken_i) begin
                        pc_sel      = SEL_BRANCH;
                        ifid_hold   = 1'b0;
                        ifid_bubble = 1'b1;
                    end else if (bus.jump_i) begin
                        pc_sel      = SEL_JUMP;
                        ifid_hold   = 1'b0;
                        ifid_bubble = 1'b1;
                    end else if (!bus.stall_i) begin
                        pc_sel    = SEL_SEQ;
                        ifid_hold = 1'b0;
                        ifid_load = 1'b1;
                    end
                end
            end
            HALT: begin
                ifid_hold   = 1'b0;
                ifid_bubble = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        pc_next = pc;
        unique case (pc_sel)
            SEL_HOLD:   pc_next = pc;
            SEL_SEQ:    pc_next = pc_plus4;
            SEL_BRANCH: pc_next = branch_target;
            SEL_JUMP:   pc_next = jump_target;
            default:    pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            fault <= 1'b0;
        end else begin
            pc <= pc_next;
            if (fault_set) begin
                fault <= 1'b1;
            end
        end
    end

    ifid_pipe_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_ifid (
        .clk           (clk),
        .rst_n         (rst_n),
        .hold          (ifid_hold),
        .bubble        (ifid_bubble),
        .load          (ifid_load),
        .next_instr    (bus.rom_data_i),
        .next_pc_plus4 (pc_plus4),
        .instr         (ifid_instr),
        .pc_plus4      (ifid_pc_plus4),
        .valid         (ifid_valid)
    );

    assign bus.pc_addr_o       = pc;
    assign bus.cs_rom_o        = cs_rom;
    assign bus.ifid_instr_o    = ifid_instr;
    assign bus.ifid_pc_plus4_o = ifid_pc_plus4;
    assign bus.ifid_valid_o    = ifid_valid;
    assign bus.fetch_fault_o   = fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table on an in-range core plus fault and reset sequences.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if m_if ();
    fetch_unit_if oor_if ();
    fetch_unit_if mis_if ();

    logic [31:0] rom [64];
    assign m_if.rom_data_i   = rom[m_if.pc_addr_o[7:2]];
    assign oor_if.rom_data_i = 32'hDEAD_BEEF;
    assign mis_if.rom_data_i = 32'hDEAD_BEEF;

    fetch_unit #(.RESET_PC(32'h0000_0000), .ROM_DEPTH(256), .NOP_WORD(32'h0000_0000)) u_main (
        .clk(clk), .rst_n(rst_n), .bus(m_if.slave));
    fetch_unit #(.RESET_PC(32'h0000_0100), .ROM_DEPTH(256), .NOP_WORD(32'h0000_0000)) u_oor (
        .clk(clk), .rst_n(rst_n), .bus(oor_if.slave));
    fetch_unit #(.RESET_PC(32'h0000_0002), .ROM_DEPTH(256), .NOP_WORD(32'h0000_0000)) u_mis (
        .clk(clk), .rst_n(rst_n), .bus(mis_if.slave));

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] imm;
        logic        jmp;
        logic [25:0] tgt;
        logic [31:0] pc;
        logic        cs;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        fault;
    } vec_t;

    vec_t vecs[28];
    int   tests = 0;
    int   failed = 0;

    function automatic vec_t mk(input logic s, input logic b, input logic [15:0] im, input logic j,
                                input logic [25:0] t, input logic [31:0] p, input logic c,
                                input logic [31:0] ins, input logic [31:0] p4, input logic v,
                                input logic f);
        vec_t r;
        r.stall = s; r.br = b; r.imm = im; r.jmp = j; r.tgt = t;
        r.pc = p; r.cs = c; r.instr = ins; r.pc4 = p4; r.valid = v; r.fault = f;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fault_ifs(input logic on);
        oor_if.stall_i = 1'b0; oor_if.branch_taken_i = on; oor_if.branch_imm_i = 16'h0002;
        oor_if.jump_i = on;    oor_if.jump_target_i = 26'h5;
        mis_if.stall_i = 1'b0; mis_if.branch_taken_i = on; mis_if.branch_imm_i = 16'h0002;
        mis_if.jump_i = on;    mis_if.jump_target_i = 26'h5;
    endtask

    task automatic check_fault_dut(input string tag, input logic [31:0] pc_exp, input logic fault_exp,
                                   input logic [31:0] pc_act, input logic cs_act,
                                   input logic fault_act, input logic valid_act);
        check({tag, " pc"}, pc_act, pc_exp);
        check({tag, " cs"}, 32'(cs_act), 32'd0);
        check({tag, " fault"}, 32'(fault_act), 32'(fault_exp));
        check({tag, " valid"}, 32'(valid_act), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hC000_0000 | 32'(i);
        rom[0] = 32'h2001_0008;
        rom[1] = 32'h3402_000C;

        //                stall br  imm       jmp tgt     pc            cs  instr          pc4           v  f
        vecs[0]  = mk(0, 0, 16'h0,    0, 26'h0,  32'h00, 1, 32'h0,         32'h00, 0, 0);
        vecs[1]  = mk(0, 0, 16'h0,    0, 26'h0,  32'h04, 1, 32'h2001_0008, 32'h04, 1, 0);
        vecs[2]  = mk(0, 0, 16'h0,    0, 26'h0,  32'h08, 1, 32'h3402_000C, 32'h08, 1, 0);
        vecs[3]  = mk(0, 0, 16'h0,    0, 26'h0,  32'h0C, 1, 32'hC000_0002, 32'h0C, 1, 0);
        vecs[4]  = mk(0, 0, 16'h0,    0, 26'h0,  32'h10, 1, 32'hC000_0003, 32'h10, 1, 0);
        vecs[5]  = mk(0, 0, 16'h0,    0, 26'h0,  32'h14, 1, 32'hC000_0004, 32'h14, 1, 0);
        vecs[6]  = mk(0, 0, 16'h0,    0, 26'h0,  32'h18, 1, 32'hC000_0005, 32'h18, 1, 0);
        vecs[7]  = mk(0, 0, 16'h0,    0, 26'h0,  32'h1C, 1, 32'hC000_0006, 32'h1C, 1, 0);
        vecs[8]  = mk(0, 1, 16'h0002, 0, 26'h0,  32'h24, 1, 32'h0,         32'h00, 0, 0);
        vecs[9]  = mk(0, 0, 16'h0,    0, 26'h0,  32'h28, 1, 32'hC000_0009, 32'h28, 1, 0);
        vecs[10] = mk(0, 0, 16'h0,    0, 26'h0,  32'h2C, 1, 32'hC000_000A, 32'h2C, 1, 0);
        vecs[11] = mk(0, 0, 16'h0,    1, 26'hD,  32'h34, 1, 32'h0,         32'h00, 0, 0);
        vecs[12] = mk(0, 0, 16'h0,    0, 26'h0,  32'h38, 1, 32'hC000_000D, 32'h38, 1, 0);
        vecs[13] = mk(0, 0, 16'h0,    0, 26'h0,  32'h3C, 1, 32'hC000_000E, 32'h3C, 1, 0);
        vecs[14] = mk(1, 0, 16'h0,    0, 26'h0,  32'h3C, 1, 32'hC000_000E, 32'h3C, 1, 0);
        vecs[15] = mk(1, 0, 16'h0,    0, 26'h0,  32'h3C, 1, 32'hC000_000E, 32'h3C, 1, 0);
        vecs[16] = mk(1, 0, 16'h0,    0, 26'h0,  32'h3C, 1, 32'hC000_000E, 32'h3C, 1, 0);
        vecs[17] = mk(0, 0, 16'h0,    0, 26'h0,  32'h40, 1, 32'hC000_000F, 32'h40, 1, 0);
        vecs[18] = mk(0, 0, 16'h0,    0, 26'h0,  32'h44, 1, 32'hC000_0010, 32'h44, 1, 0);
        vecs[19] = mk(0, 0, 16'h0,    0, 26'h0,  32'h48, 1, 32'hC000_0011, 32'h48, 1, 0);
        vecs[20] = mk(1, 1, 16'hFFFF, 0, 26'h0,  32'h44, 1, 32'h0,         32'h00, 0, 0);
        vecs[21] = mk(0, 0, 16'h0,    0, 26'h0,  32'h48, 1, 32'hC000_0011, 32'h48, 1, 0);
        vecs[22] = mk(0, 1, 16'h0001, 1, 26'h0,  32'h4C, 1, 32'h0,         32'h00, 0, 0);
        vecs[23] = mk(0, 0, 16'h0,    0, 26'h0,  32'h50, 1, 32'hC000_0013, 32'h50, 1, 0);
        vecs[24] = mk(0, 0, 16'h0,    1, 26'h3F, 32'hFC, 1, 32'h0,         32'h00, 0, 0);
        vecs[25] = mk(0, 0, 16'h0,    0, 26'h0,  32'h100, 0, 32'hC000_003F, 32'h100, 1, 0);
        vecs[26] = mk(0, 0, 16'h0,    0, 26'h0,  32'h100, 0, 32'h0,        32'h00, 0, 1);
        vecs[27] = mk(0, 1, 16'h0002, 1, 26'h5,  32'h100, 0, 32'h0,        32'h00, 0, 1);

        m_if.stall_i = 1'b0; m_if.branch_taken_i = 1'b0; m_if.branch_imm_i = '0;
        m_if.jump_i = 1'b0;  m_if.jump_target_i = '0;
        drive_fault_ifs(1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("rst pc", m_if.pc_addr_o, 32'h0);
        check("rst cs", 32'(m_if.cs_rom_o), 32'd0);
        check("rst instr", m_if.ifid_instr_o, 32'h0);
        check("rst valid", 32'(m_if.ifid_valid_o), 32'd0);
        check("rst fault", 32'(m_if.fetch_fault_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("boot cs", 32'(m_if.cs_rom_o), 32'd0);
        check("boot pc", m_if.pc_addr_o, 32'h0);

        for (int i = 0; i < 28; i++) begin
            m_if.stall_i        = vecs[i].stall;
            m_if.branch_taken_i = vecs[i].br;
            m_if.branch_imm_i   = vecs[i].imm;
            m_if.jump_i         = vecs[i].jmp;
            m_if.jump_target_i  = vecs[i].tgt;
            step();
            check($sformatf("v%0d pc", i),    m_if.pc_addr_o,           vecs[i].pc);
            check($sformatf("v%0d cs", i),    32'(m_if.cs_rom_o),       32'(vecs[i].cs));
            check($sformatf("v%0d instr", i), m_if.ifid_instr_o,        vecs[i].instr);
            check($sformatf("v%0d pc4", i),   m_if.ifid_pc_plus4_o,     vecs[i].pc4);
            check($sformatf("v%0d valid", i), 32'(m_if.ifid_valid_o),   32'(vecs[i].valid));
            check($sformatf("v%0d fault", i), 32'(m_if.fetch_fault_o),  32'(vecs[i].fault));
        end

        m_if.stall_i = 1'b0; m_if.branch_taken_i = 1'b0; m_if.jump_i = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("async pc", m_if.pc_addr_o, 32'h0);
        check("async fault", 32'(m_if.fetch_fault_o), 32'd0);
        check("async cs", 32'(m_if.cs_rom_o), 32'd0);
        check("async valid", 32'(m_if.ifid_valid_o), 32'd0);
        check("async oor fault", 32'(oor_if.fetch_fault_o), 32'd0);
        check("async mis pc", mis_if.pc_addr_o, 32'h2);

        @(negedge clk);
        rst_n = 1'b1;
        drive_fault_ifs(1'b1);
        #1;
        check("reboot cs", 32'(m_if.cs_rom_o), 32'd0);
        check_fault_dut("oor boot", 32'h100, 1'b0, oor_if.pc_addr_o, oor_if.cs_rom_o,
                        oor_if.fetch_fault_o, oor_if.ifid_valid_o);
        check_fault_dut("mis boot", 32'h2, 1'b0, mis_if.pc_addr_o, mis_if.cs_rom_o,
                        mis_if.fetch_fault_o, mis_if.ifid_valid_o);

        step();
        check("reboot run pc", m_if.pc_addr_o, 32'h0);
        check("reboot run cs", 32'(m_if.cs_rom_o), 32'd1);
        check_fault_dut("oor run", 32'h100, 1'b0, oor_if.pc_addr_o, oor_if.cs_rom_o,
                        oor_if.fetch_fault_o, oor_if.ifid_valid_o);
        check_fault_dut("mis run", 32'h2, 1'b0, mis_if.pc_addr_o, mis_if.cs_rom_o,
                        mis_if.fetch_fault_o, mis_if.ifid_valid_o);

        step();
        check("reboot pc4", m_if.pc_addr_o, 32'h4);
        check("reboot instr0", m_if.ifid_instr_o, 32'h2001_0008);
        check_fault_dut("oor halt", 32'h100, 1'b1, oor_if.pc_addr_o, oor_if.cs_rom_o,
                        oor_if.fetch_fault_o, oor_if.ifid_valid_o);
        check_fault_dut("mis halt", 32'h2, 1'b1, mis_if.pc_addr_o, mis_if.cs_rom_o,
                        mis_if.fetch_fault_o, mis_if.ifid_valid_o);

        step();
        check("reboot pc8", m_if.pc_addr_o, 32'h8);
        check("reboot instr1", m_if.ifid_instr_o, 32'h3402_000C);
        check("reboot ifid pc4", m_if.ifid_pc_plus4_o, 32'h8);
        check_fault_dut("oor sticky", 32'h100, 1'b1, oor_if.pc_addr_o, oor_if.cs_rom_o,
                        oor_if.fetch_fault_o, oor_if.ifid_valid_o);
        check_fault_dut("mis sticky", 32'h2, 1'b1, mis_if.pc_addr_o, mis_if.cs_rom_o,
                        mis_if.fetch_fault_o, mis_if.ifid_valid_o);
        check("oor instr nop", oor_if.ifid_instr_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage sitting directly upstream of the instruction ROM.
- Drives the ROM address and chip-select, captures the 32-bit little-endian assembled word into the IF/ID pipeline register, and applies redirects (branch/jump) and stalls from ID.
- Detects out-of-range or misaligned fetch and halts.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ROM_DEPTH, 256, ROM size in bytes; legal fetch requires pc <= ROM_DEPTH-4.
- NOP_WORD, 32'h0000_0000, instruction injected into IF/ID on a bubble.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold PC and IF/ID, e.g. load-use hazard.
- branch_taken_i  in  1  branch in ID resolved taken.
- branch_imm_i  in  16  branch immediate, in words, signed.
- jump_i  in  1  jump in ID.
- jump_target_i  in  26  jump target field, in words.
- rom_data_i  in  32  assembled instruction word from the ROM.
- pc_addr_o  out  32  byte address to the ROM, equal to the current pc.
- cs_rom_o  out  1  ROM chip-select.
- ifid_instr_o  out  32  IF/ID instruction.
- ifid_pc_plus4_o  out  32  IF/ID pc+4 of that instruction.
- ifid_valid_o  out  1  IF/ID contents valid.
- fetch_fault_o  out  1  sticky fault flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values:
  - pc = RESET_PC and state = BOOT.
  - ifid_instr_o = NOP_WORD, ifid_pc_plus4_o = 0, ifid_valid_o = 0.
  - fetch_fault_o = 0, cs_rom_o = 0.
- The ROM is combinational. rom_data_i is sampled in the same cycle that pc_addr_o is presented.
- States:
  - BOOT: one cycle after reset release. cs_rom_o = 0, pc holds, IF/ID holds its reset values. Always goes to RUN.
  - RUN: compute bad = (pc[1:0] != 0) OR (pc > ROM_DEPTH-4).
    - If bad: cs_rom_o = 0, IF/ID <= {NOP_WORD, 0, valid 0}, fetch_fault_o <= 1, next state HALT.
    - Otherwise cs_rom_o = 1 and the priority list below applies.
  - HALT: terminal until reset. cs_rom_o = 0, pc frozen, IF/ID valid = 0, all inputs ignored.
- Priority in RUN when the fetch is not bad (highest first):
  1. branch_taken_i:
     - pc <= ifid_pc_plus4_o + (sign_extend(branch_imm_i) << 2), 32-bit wrap.
     - IF/ID <= bubble (NOP_WORD, valid 0).
  2. jump_i:
     - pc <= {ifid_pc_plus4_o[31:28], jump_target_i, 2'b00}.
     - IF/ID <= bubble.
  3. stall_i:
     - pc and IF/ID hold.
     - cs_rom_o stays 1 on the same address.
  4. Otherwise:
     - pc <= pc+4.
     - IF/ID <= {rom_data_i, pc+4, valid 1}.
- A redirect overrides a simultaneous stall.
- branch_taken_i together with jump_i: the branch wins.
- Redirect target bounds are not checked at redirect time. They are checked on the next RUN cycle through the bad test.
- pc+4 wraps modulo 2^32.
- Latency: an instruction at address A appears on ifid_instr_o one cycle after pc_addr_o == A with no stall.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). The next fetch sequence restarts with BOOT.

Decomposition:
- Shared package (fetch_pkg):
  - state encodings BOOT/RUN/HALT (2-bit);
  - PC_INC = 32'd4;
  - NOP_WORD default;
  - the redirect-select encoding.
- Reuse the existing adder_32_bit twice, once for pc+4 and once for the branch target.
- One natural sub-module: ifid_pipe_reg, holding instr, pc_plus4 and valid, with hold, bubble and load controls and asynchronous active-low reset.

Test Plan:
- Reset release with the ROM program loaded:
  - cycle 0 is BOOT with cs_rom_o = 0;
  - the following cycles show pc_addr_o 0x0, 0x4, 0x8;
  - ifid_instr_o = 0x20010008 then 0x3402000C, ifid_valid_o = 1, ifid_pc_plus4_o = 0x4 then 0x8.
- Taken branch:
  - stimulus: ifid_pc_plus4_o = 0x1C, branch_taken_i = 1, branch_imm_i = 0x0002;
  - next cycle: pc_addr_o = 0x24 and ifid_valid_o = 0;
  - one cycle later: the word at 0x24 appears valid.
- Jump:
  - stimulus: ifid_pc_plus4_o = 0x2C, jump_i = 1, jump_target_i = 0x000000D;
  - next cycle: pc_addr_o = 0x34, IF/ID bubble.
- Stall:
  - stimulus: stall_i held 3 cycles at pc = 0x3C;
  - response: pc_addr_o stays 0x3C, IF/ID is unchanged, cs_rom_o = 1;
  - on release: pc = 0x40.
- Stall with simultaneous branch:
  - stimulus: stall_i = 1, branch_taken_i = 1, branch_imm_i = 0xFFFF, ifid_pc_plus4_o = 0x48;
  - response: pc <= 0x44, bubble inserted.
- Fault, out of range:
  - stimulus: RESET_PC = 0x100 with ROM_DEPTH = 256;
  - first RUN cycle: cs_rom_o = 0, then fetch_fault_o = 1 and sticky; branch/jump are ignored.
- Fault, misaligned:
  - stimulus: RESET_PC = 0x2;
  - response: same as out of range.
- Reset mid-run:
  - stimulus: pulse rst_n low;
  - response: pc returns to RESET_PC immediately, fetch_fault_o clears, and the sequence restarts with BOOT.
